// File: rtl/rx_frame_assembler.sv
// Packs rate-1/2 or rate-1/3 code symbols into TRACEBACK_DEPTH-bit frames for the Viterbi decoder.
// An assembly register and an output register let the next frame fill while the decoder holds one.
module rx_frame_assembler #(
  parameter int unsigned TRACEBACK_DEPTH = 48,
  parameter int unsigned MAX_CODE_RATE   = 3
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       i_code_rate,
  input  logic [MAX_CODE_RATE-1:0]   i_sym,
  input  logic                       i_sym_valid,
  output logic                       o_sym_ready,
  input  logic                       i_flush,
  output logic [TRACEBACK_DEPTH-1:0] o_frame,
  output logic                       o_frame_valid,
  input  logic                       i_frame_ready,
  output logic                       o_frame_padded
);

  localparam int unsigned   TD     = TRACEBACK_DEPTH;
  localparam int unsigned   CW     = $clog2(TD + 1);
  localparam logic [CW-1:0] TdBits = CW'(TD);
  localparam logic [CW-1:0] NHalf  = CW'(TD / 2);
  localparam logic [CW-1:0] NThird = CW'(TD / 3);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e        state_q;
  logic [TD-1:0] asm_q;
  logic [TD-1:0] frame_q;
  logic [CW-1:0] cnt_q;
  logic          rate_q;
  logic          valid_q;
  logic          padded_q;
  logic          hold_padded_q;

  logic          accept;
  logic          rate_eff;
  logic          full;
  logic          flush_close;
  logic          close;
  logic          slot_free;
  logic [CW-1:0] sym_bits;
  logic [CW-1:0] sym_total;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] pad_bits;
  logic [TD-1:0] asm_shift;
  logic [TD-1:0] close_data;

  always_comb begin
    accept    = (state_q == StFill) && i_sym_valid;
    // The rate is taken live on the first symbol of a frame, latched afterwards.
    rate_eff  = (cnt_q == '0) ? i_code_rate : rate_q;
    sym_bits  = rate_eff ? CW'(3) : CW'(2);
    sym_total = rate_eff ? NThird : NHalf;
    cnt_inc   = cnt_q + CW'(accept);
    asm_shift = asm_q;
    if (accept) begin
      asm_shift = rate_eff ? {asm_q[TD-4:0], i_sym[2:0]} : {asm_q[TD-3:0], i_sym[1:0]};
    end
    full        = accept && (cnt_inc == sym_total);
    flush_close = (state_q == StFill) && i_flush && !full && (cnt_inc != '0);
    close       = full || flush_close;
    // Stale bits above the partial frame shift out; zeros fill from the bottom.
    pad_bits    = TdBits - cnt_inc * sym_bits;
    close_data  = flush_close ? (asm_shift << pad_bits) : asm_shift;
    slot_free   = !valid_q || i_frame_ready;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q       <= StFill;
      asm_q         <= '0;
      frame_q       <= '0;
      cnt_q         <= '0;
      rate_q        <= 1'b0;
      valid_q       <= 1'b0;
      padded_q      <= 1'b0;
      hold_padded_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            asm_q <= asm_shift;
            cnt_q <= cnt_inc;
            if (cnt_q == '0) rate_q <= i_code_rate;
          end
          if (close) begin
            cnt_q <= '0;
            if (slot_free) begin
              frame_q  <= close_data;
              padded_q <= flush_close;
              valid_q  <= 1'b1;
            end else begin
              asm_q         <= close_data;
              hold_padded_q <= flush_close;
              state_q       <= StHold;
            end
          end else if (valid_q && i_frame_ready) begin
            valid_q <= 1'b0;
          end
        end
        StHold: begin
          // valid_q is always set here, so a drain hands over with no bubble.
          if (i_frame_ready) begin
            frame_q  <= asm_q;
            padded_q <= hold_padded_q;
            state_q  <= StFill;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign o_sym_ready    = (state_q == StFill);
  assign o_frame        = frame_q;
  assign o_frame_valid  = valid_q;
  assign o_frame_padded = padded_q;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Bench for rx_frame_assembler: directed scenarios plus random traffic against a frame-level
// scoreboard built from the accepted symbol stream.
module tb_rx_frame_assembler;

  localparam int TD = 48;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_code_rate = 1'b0;
  logic [2:0]    i_sym = '0;
  logic          i_sym_valid = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_frame_ready = 1'b1;
  logic          o_sym_ready;
  logic          o_frame_valid;
  logic          o_frame_padded;
  logic [TD-1:0] o_frame;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  rx_frame_assembler #(
    .TRACEBACK_DEPTH(TD),
    .MAX_CODE_RATE  (3)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .i_code_rate   (i_code_rate),
    .i_sym         (i_sym),
    .i_sym_valid   (i_sym_valid),
    .o_sym_ready   (o_sym_ready),
    .i_flush       (i_flush),
    .o_frame       (o_frame),
    .o_frame_valid (o_frame_valid),
    .i_frame_ready (i_frame_ready),
    .o_frame_padded(o_frame_padded)
  );

  // Frame = symbols concatenated first-in-MSB, zero filled below.
  function automatic logic [TD-1:0] build_frame(input logic [2:0] syms[$], input bit rate);
    int n;
    logic [TD-1:0] f;
    logic [TD-1:0] s;
    n = rate ? 3 : 2;
    f = '0;
    for (int i = 0; i < syms.size(); i++) begin
      s = rate ? TD'(syms[i]) : TD'(syms[i][1:0]);
      f |= s << (TD - (i + 1) * n);
    end
    return f;
  endfunction

  // Reference model: symbol stream in, closed frames out, in order.
  logic [2:0]    cur_syms[$];
  bit            cur_rate;
  logic [TD-1:0] exp_frames[$];
  logic [TD-1:0] obs_frames[$];
  bit            exp_pads[$];
  bit            obs_pads[$];

  always @(negedge sys_clk) begin
    if (rst) begin
      cur_syms.delete();
      while (exp_frames.size() > obs_frames.size()) begin
        void'(exp_frames.pop_back());
        void'(exp_pads.pop_back());
      end
    end else begin
      if (o_frame_valid && i_frame_ready) begin
        obs_frames.push_back(o_frame);
        obs_pads.push_back(o_frame_padded);
      end
      if (o_sym_ready) begin
        if (i_sym_valid) begin
          if (cur_syms.size() == 0) cur_rate = i_code_rate;
          cur_syms.push_back(i_sym);
        end
        if (cur_syms.size() == (cur_rate ? TD / 3 : TD / 2)) begin
          exp_frames.push_back(build_frame(cur_syms, cur_rate));
          exp_pads.push_back(1'b0);
          cur_syms.delete();
        end else if (i_flush && cur_syms.size() != 0) begin
          exp_frames.push_back(build_frame(cur_syms, cur_rate));
          exp_pads.push_back(1'b1);
          cur_syms.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Offer one symbol until accepted; returns just after the accepting edge with valid still high.
  task automatic send_sym(input logic [2:0] sym, input logic rate);
    bit got;
    got = 1'b0;
    i_sym       = sym;
    i_code_rate = rate;
    i_sym_valid = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge sys_clk);
      got = o_sym_ready;
      @(posedge sys_clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: o_sym_ready=%b required 1 within 200 cycles", o_sym_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_frame !== '0) begin errors++; $display("FAIL rst_frame: got %h want 0", o_frame); end
    checks++;
    if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_frame_valid); end
    checks++;
    if (o_frame_padded !== 1'b0) begin errors++; $display("FAIL rst_padded: got %b want 0", o_frame_padded); end
    checks++;
    if (o_sym_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", o_sym_ready); end
    tick();
  endtask

  task automatic test_rate_half();
    logic [TD-1:0] want;
    want = {24{2'b10}};
    i_frame_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      // Bit 2 is junk at rate 1/2 and must not reach the frame.
      send_sym({1'($urandom), 2'b10}, 1'b0);
      if (i == 22) begin
        i_sym_valid = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL half_early: valid=%b want 0", o_frame_valid); end
        tick();
      end
    end
    i_sym_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL half_valid: got %b want 1", o_frame_valid); end
    checks++;
    if (o_frame !== want) begin errors++; $display("FAIL half_data: got %h want %h", o_frame, want); end
    checks++;
    if (o_frame_padded !== 1'b0) begin errors++; $display("FAIL half_padded: got %b want 0", o_frame_padded); end
    tick();
    @(negedge sys_clk);
    checks++;
    if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL half_one_cycle: valid=%b want 0", o_frame_valid); end
    tick();
  endtask

  task automatic test_rate_third();
    logic [2:0] q[$];
    logic [TD-1:0] want;
    for (int i = 0; i < 16; i++) begin
      q.push_back(3'(i));
      send_sym(3'(i), 1'b1);
    end
    want = build_frame(q, 1'b1);
    i_sym_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL third_valid: got %b want 1", o_frame_valid); end
    checks++;
    if (o_frame[TD-1 -: 3] !== 3'd0) begin errors++; $display("FAIL third_msb: got %0d want 0", o_frame[TD-1 -: 3]); end
    checks++;
    if (o_frame[2:0] !== 3'd7 + 3'd0 && o_frame[2:0] !== 3'(15)) begin
      errors++; $display("FAIL third_lsb: got %0d want %0d", o_frame[2:0], 3'(15));
    end
    checks++;
    if (o_frame !== want) begin errors++; $display("FAIL third_data: got %h want %h", o_frame, want); end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [2:0] q1[$];
    logic [2:0] q2[$];
    logic [2:0] s;
    logic [TD-1:0] f1;
    logic [TD-1:0] f2;
    i_frame_ready = 1'b0;
    for (int i = 0; i < 48; i++) begin
      s = 3'($urandom);
      if (i < 24) q1.push_back(s);
      else q2.push_back(s);
      send_sym(s, 1'b0);
    end
    f1 = build_frame(q1, 1'b0);
    f2 = build_frame(q2, 1'b0);
    i_sym_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      checks++;
      if (o_sym_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", o_sym_ready); end
      checks++;
      if (o_frame_valid !== 1'b1 || o_frame !== f1) begin
        errors++; $display("FAIL bp_hold: valid=%b frame=%h want 1 %h", o_frame_valid, o_frame, f1);
      end
      tick();
    end
    i_frame_ready = 1'b1;
    tick();
    @(negedge sys_clk);
    checks++;
    if (o_frame_valid !== 1'b1 || o_frame !== f2) begin
      errors++; $display("FAIL bp_frame2: valid=%b frame=%h want 1 %h", o_frame_valid, o_frame, f2);
    end
    checks++;
    if (o_sym_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", o_sym_ready); end
    tick();
    tick();
  endtask

  task automatic test_flush();
    logic [TD-1:0] want;
    want = {{15{1'b1}}, {33{1'b0}}};
    for (int i = 0; i < 5; i++) send_sym(3'b111, 1'b1);
    i_sym_valid = 1'b0;
    i_flush     = 1'b1;
    tick();
    i_flush = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_frame_valid !== 1'b1 || o_frame !== want) begin
      errors++; $display("FAIL flush_data: valid=%b frame=%h want 1 %h", o_frame_valid, o_frame, want);
    end
    checks++;
    if (o_frame_padded !== 1'b1) begin errors++; $display("FAIL flush_padded: got %b want 1", o_frame_padded); end
    tick();
    i_flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      checks++;
      if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: valid=%b want 0", o_frame_valid); end
      tick();
    end
    i_flush = 1'b0;
    // Flush arriving with the last symbol gives an ordinary full frame.
    for (int i = 0; i < 23; i++) send_sym(3'($urandom), 1'b0);
    i_flush = 1'b1;
    send_sym(3'($urandom), 1'b0);
    i_flush     = 1'b0;
    i_sym_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_frame_valid !== 1'b1 || o_frame_padded !== 1'b0) begin
      errors++; $display("FAIL flush_last: valid=%b padded=%b want 1 0", o_frame_valid, o_frame_padded);
    end
    tick();
  endtask

  task automatic test_rate_switch();
    logic [2:0] q[$];
    logic [2:0] s;
    logic [TD-1:0] want;
    for (int i = 0; i < 24; i++) begin
      s = 3'($urandom);
      q.push_back(s);
      send_sym(s, (i >= 3) ? 1'b1 : 1'b0);
      if (i == 15) begin
        i_sym_valid = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL switch_at16: valid=%b want 0", o_frame_valid); end
        tick();
      end
    end
    want = build_frame(q, 1'b0);
    i_sym_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_frame_valid !== 1'b1 || o_frame !== want) begin
      errors++; $display("FAIL switch_frame: valid=%b frame=%h want 1 %h", o_frame_valid, o_frame, want);
    end
    tick();
    q.delete();
    for (int i = 0; i < 16; i++) begin
      s = 3'($urandom);
      q.push_back(s);
      send_sym(s, 1'b1);
    end
    want = build_frame(q, 1'b1);
    i_sym_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_frame_valid !== 1'b1 || o_frame !== want) begin
      errors++; $display("FAIL switch_next: valid=%b frame=%h want 1 %h", o_frame_valid, o_frame, want);
    end
    tick();
  endtask

  task automatic test_reset_hold();
    logic [2:0] q[$];
    logic [2:0] s;
    logic [TD-1:0] want;
    i_frame_ready = 1'b0;
    for (int i = 0; i < 48; i++) send_sym(3'($urandom), 1'b0);
    i_sym_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_sym_ready !== 1'b0 || o_frame_valid !== 1'b1) begin
      errors++; $display("FAIL rsth_pre: ready=%b valid=%b want 0 1", o_sym_ready, o_frame_valid);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_frame_valid !== 1'b0 || o_sym_ready !== 1'b1) begin
      errors++; $display("FAIL rsth_post: valid=%b ready=%b want 0 1", o_frame_valid, o_sym_ready);
    end
    checks++;
    if (o_frame !== '0 || o_frame_padded !== 1'b0) begin
      errors++; $display("FAIL rsth_clear: frame=%h padded=%b want 0 0", o_frame, o_frame_padded);
    end
    tick();
    i_frame_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s = 3'($urandom);
      q.push_back(s);
      send_sym(s, 1'b1);
    end
    want = build_frame(q, 1'b1);
    i_sym_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_frame_valid !== 1'b1 || o_frame !== want) begin
      errors++; $display("FAIL rsth_fresh: valid=%b frame=%h want 1 %h", o_frame_valid, o_frame, want);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      i_sym_valid   = ($urandom_range(0, 3) != 0);
      i_sym         = 3'($urandom);
      i_code_rate   = 1'($urandom_range(0, 1));
      i_flush       = ($urandom_range(0, 15) == 0);
      i_frame_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    i_sym_valid   = 1'b0;
    i_flush       = 1'b0;
    i_frame_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_scoreboard();
    int n;
    checks++;
    if (obs_frames.size() != exp_frames.size()) begin
      errors++; $display("FAIL sb_count: got %0d frames want %0d", obs_frames.size(), exp_frames.size());
    end
    n = (obs_frames.size() < exp_frames.size()) ? obs_frames.size() : exp_frames.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_frames[i] !== exp_frames[i] || obs_pads[i] !== exp_pads[i]) begin
        errors++;
        $display("FAIL sb_frame[%0d]: got %h/%b want %h/%b", i, obs_frames[i], obs_pads[i],
                 exp_frames[i], exp_pads[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rate_half();
    test_rate_third();
    test_back_pressure();
    test_flush();
    test_rate_switch();
    test_reset_hold();
    test_random();
    test_scoreboard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
